// File: rtl/universal_counter_pkg.sv
// Shared mode encoding for the universal counter.
// Build option: UNIVERSAL_COUNTER_SATURATE_EN (see universal_counter_next).
package universal_counter_pkg;

  typedef logic [1:0] modeT;

  localparam modeT MODE_HOLD = 2'b00;
  localparam modeT MODE_UP   = 2'b01;
  localparam modeT MODE_DOWN = 2'b10;
  localparam modeT MODE_LOAD = 2'b11;

endpackage

// File: rtl/universal_counter_next.sv
// Combinational next-state for the universal counter: next Q, terminal flag, wrap-count clear.
// UNIVERSAL_COUNTER_SATURATE_EN selects clamp-at-bound instead of wrap-to-opposite-bound.
module universal_counter_next
  import universal_counter_pkg::*;
#(
  parameter int unsigned WIDTH = 10
) (
  input  logic [WIDTH-1:0] q_i,
  input  modeT             mode_i,
  input  logic             countEnable_i,
  input  logic [WIDTH-1:0] p_i,
  input  logic [WIDTH-1:0] beginCount_i,
  input  logic [WIDTH-1:0] endCount_i,
  input  logic [WIDTH-1:0] step_i,
  output logic [WIDTH-1:0] qNext_o,
  output logic             terminal_o,
  output logic             clearWrap_o
);

  logic [WIDTH-1:0]        stepEff;
  logic [WIDTH:0]          sum;
  logic signed [WIDTH:0]   diff;
  logic                    narrowWindow;
  logic                    upEvent;
  logic                    downEvent;

  assign stepEff = (step_i == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : step_i;
  assign sum     = {1'b0, q_i} + {1'b0, stepEff};
  assign diff    = $signed({1'b0, q_i}) - $signed({1'b0, stepEff});

  // An empty or single-point window turns every enabled count into a terminal event.
  assign narrowWindow = (beginCount_i >= endCount_i);

  assign upEvent   = narrowWindow || (q_i >= endCount_i) || (sum > {1'b0, endCount_i});
  assign downEvent = narrowWindow || (q_i <= beginCount_i) ||
                     (diff < $signed({1'b0, beginCount_i}));

  always_comb begin
    qNext_o     = q_i;
    terminal_o  = 1'b0;
    clearWrap_o = 1'b0;
    case (mode_i)
      MODE_LOAD: begin
        qNext_o     = p_i;
        clearWrap_o = 1'b1;
      end
      MODE_UP: begin
        if (countEnable_i) begin
          if (upEvent) begin
            terminal_o = 1'b1;
`ifdef UNIVERSAL_COUNTER_SATURATE_EN
            qNext_o    = endCount_i;
`else
            qNext_o    = beginCount_i;
`endif
          end else begin
            qNext_o = sum[WIDTH-1:0];
          end
        end
      end
      MODE_DOWN: begin
        if (countEnable_i) begin
          if (downEvent) begin
            terminal_o = 1'b1;
`ifdef UNIVERSAL_COUNTER_SATURATE_EN
            qNext_o    = beginCount_i;
`else
            qNext_o    = endCount_i;
`endif
          end else begin
            qNext_o = diff[WIDTH-1:0];
          end
        end
      end
      default: begin
        qNext_o = q_i;
      end
    endcase
  end

endmodule

// File: rtl/universal_counter_n.sv
// Universal bidirectional windowed counter with registered terminal pulse and saturating
// wrap counter. Build option: UNIVERSAL_COUNTER_SATURATE_EN (clamp instead of wrap).
module universal_counter_n
  import universal_counter_pkg::*;
#(
  parameter int unsigned     WIDTH       = 10,
  parameter int unsigned     CW          = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [1:0]       S,
  input  logic             CountEnable,
  input  logic [WIDTH-1:0] P,
  input  logic [WIDTH-1:0] BeginCount,
  input  logic [WIDTH-1:0] EndCount,
  input  logic [WIDTH-1:0] Step,
  output logic [WIDTH-1:0] Q,
  output logic             TerminalCount,
  output logic [CW-1:0]    WrapCount
);

  logic [WIDTH-1:0] qNext;
  logic             terminalNext;
  logic             clearWrap;
  logic [CW-1:0]    wrapNext;

  universal_counter_next #(
    .WIDTH (WIDTH)
  ) u_next (
    .q_i           (Q),
    .mode_i        (modeT'(S)),
    .countEnable_i (CountEnable),
    .p_i           (P),
    .beginCount_i  (BeginCount),
    .endCount_i    (EndCount),
    .step_i        (Step),
    .qNext_o       (qNext),
    .terminal_o    (terminalNext),
    .clearWrap_o   (clearWrap)
  );

  always_comb begin
    wrapNext = WrapCount;
    if (clearWrap) begin
      wrapNext = '0;
    end else if (terminalNext && (WrapCount != '1)) begin
      wrapNext = WrapCount + CW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      Q             <= RESET_VALUE;
      TerminalCount <= 1'b0;
      WrapCount     <= '0;
    end else begin
      Q             <= qNext;
      TerminalCount <= terminalNext;
      WrapCount     <= wrapNext;
    end
  end

endmodule

// File: tb/tb_universal_counter_n.sv
// Directed self-checking bench for universal_counter_n (WIDTH=10, CW=8, RESET_VALUE=0).
// Saturate-mode expectations are selected by UNIVERSAL_COUNTER_SATURATE_EN.
module tb_universal_counter_n;

  localparam int unsigned WIDTH = 10;
  localparam int unsigned CW    = 8;

  logic             CLK;
  logic             RESET_N;
  logic [1:0]       S;
  logic             CountEnable;
  logic [WIDTH-1:0] P;
  logic [WIDTH-1:0] BeginCount;
  logic [WIDTH-1:0] EndCount;
  logic [WIDTH-1:0] Step;
  logic [WIDTH-1:0] Q;
  logic             TerminalCount;
  logic [CW-1:0]    WrapCount;

  int testsRun;
  int testsFailed;

  universal_counter_n #(
    .WIDTH       (WIDTH),
    .CW          (CW),
    .RESET_VALUE ('0)
  ) dut (
    .CLK           (CLK),
    .RESET_N       (RESET_N),
    .S             (S),
    .CountEnable   (CountEnable),
    .P             (P),
    .BeginCount    (BeginCount),
    .EndCount      (EndCount),
    .Step          (Step),
    .Q             (Q),
    .TerminalCount (TerminalCount),
    .WrapCount     (WrapCount)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkEq(input string tag, input int unsigned got, input int unsigned exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance one edge and sample 1 time unit later.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic loadQ(input int unsigned v);
    S = 2'b11;
    P = WIDTH'(v);
    tick();
  endtask

  task automatic setWindow(input int unsigned b, input int unsigned e, input int unsigned st);
    BeginCount = WIDTH'(b);
    EndCount   = WIDTH'(e);
    Step       = WIDTH'(st);
  endtask

  task automatic checkOut(input string tag, input int unsigned q, input int unsigned tc,
                          input int unsigned wc);
    checkEq({tag, ".Q"}, Q, q);
    checkEq({tag, ".TC"}, TerminalCount, tc);
    checkEq({tag, ".WC"}, WrapCount, wc);
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    RESET_N     = 1'b0;
    S           = 2'b00;
    CountEnable = 1'b1;
    P           = '0;
    setWindow(0, 1023, 1);

    #2;
    checkOut("reset", 0, 0, 0);
    #1 RESET_N = 1'b1;

    loadQ(100);
    checkOut("load", 100, 0, 0);

    S = 2'b00;
    tick();
    checkOut("hold", 100, 0, 0);

`ifndef UNIVERSAL_COUNTER_SATURATE_EN
    setWindow(10, 20, 3);
    loadQ(18);
    S = 2'b01;
    tick();
    checkOut("up_wrap", 10, 1, 1);
    tick();
    checkOut("up_after", 13, 0, 1);

    setWindow(10, 20, 4);
    loadQ(12);
    S = 2'b10;
    tick();
    checkOut("down_wrap", 20, 1, 1);
    tick();
    checkOut("down_after", 16, 0, 1);

    // Out-of-window start points
    loadQ(50);
    S = 2'b01;
    tick();
    checkOut("oow_up", 10, 1, 1);
    loadQ(3);
    S = 2'b10;
    tick();
    checkOut("oow_down", 20, 1, 1);

    // Degenerate window: every count is an event
    setWindow(20, 10, 1);
    loadQ(5);
    S = 2'b01;
    tick();
    checkOut("degen_up", 20, 1, 1);
`else
    setWindow(10, 20, 3);
    loadQ(18);
    S = 2'b01;
    tick();
    checkOut("sat_cross", 20, 1, 1);
    tick();
    checkOut("sat_hold1", 20, 1, 2);
    tick();
    checkOut("sat_hold2", 20, 1, 3);

    setWindow(10, 20, 4);
    loadQ(12);
    S = 2'b10;
    tick();
    checkOut("sat_down", 10, 1, 1);

    loadQ(50);
    S = 2'b01;
    tick();
    checkOut("sat_oow_up", 20, 1, 1);
    loadQ(3);
    S = 2'b10;
    tick();
    checkOut("sat_oow_down", 10, 1, 1);
`endif

    // Count-enable low must freeze the counter
    setWindow(0, 100, 1);
    loadQ(16);
    S = 2'b01;
    CountEnable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkEq("ce_off.Q", Q, 16);
      checkEq("ce_off.TC", TerminalCount, 0);
    end
    CountEnable = 1'b1;

    setWindow(0, 1023, 0);
    loadQ(5);
    S = 2'b01;
    tick();
    checkOut("step0", 6, 0, 0);

`ifndef UNIVERSAL_COUNTER_SATURATE_EN
    setWindow(0, 1023, 1);
    loadQ(1023);
    S = 2'b01;
    tick();
    checkOut("full_wrap", 0, 1, 1);
`endif

    // Single-point window: every enabled count is an event
    setWindow(0, 0, 1);
    loadQ(0);
    S = 2'b01;
    for (int i = 0; i < 254; i++) tick();
    checkOut("wc_254", 0, 1, 254);
    tick();
    checkOut("wc_255", 0, 1, 255);
    for (int i = 0; i < 45; i++) tick();
    checkOut("wc_sat", 0, 1, 255);

    // Asynchronous reset between edges
    setWindow(0, 1023, 1);
    loadQ(40);
    S = 2'b01;
    tick();
    tick();
    checkEq("pre_rst.Q", Q, 42);
    #2 RESET_N = 1'b0;
    #1;
    checkOut("async_rst", 0, 0, 0);
    @(negedge CLK);
    RESET_N = 1'b1;
    tick();
    checkOut("post_rst", 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/universal_counter_n.md
# universal_counter_n

Parametrised universal bidirectional counter with programmable window, step size, registered terminal-count pulse and wrap counter. It is the general counting primitive for timing and address generation in the term-project datapath. It supersedes the fixed 10-bit counter with these additions:
- configurable width and step;
- symmetric wrap to the window bounds in both directions;
- a count-enable for cascading;
- an asynchronous active-low reset to a constant value.

## Interface
- WIDTH, 10, counter width in bits
- CW, 8, width of the wrap counter
- RESET_VALUE, 0, value of Q after reset (WIDTH bits)
- CLK  input  1  rising-edge clock; single clock domain
- RESET_N  input  1  asynchronous, active-low reset
- S  input  2  mode: 00 hold, 01 count up, 10 count down, 11 parallel load
- CountEnable  input  1  gates up/down counting; ignored for hold and load
- P  input  WIDTH  parallel load value
- BeginCount  input  WIDTH  lower window bound
- EndCount  input  WIDTH  upper window bound
- Step  input  WIDTH  increment/decrement magnitude; 0 is treated as 1
- Q  output  WIDTH  counter value (registered)
- TerminalCount  output  1  registered one-cycle pulse, coincident with Q taking a wrap/bound value
- WrapCount  output  CW  number of terminal events since reset or last load; saturates at all-ones

## Operation
- Reset (RESET_N=0, asynchronous):
  - Q=RESET_VALUE, TerminalCount=0, WrapCount=0.
  - Release is sampled on the next CLK rising edge.
- Hold (00), or up/down with CountEnable=0:
  - Q, WrapCount unchanged; TerminalCount=0.
- Load (11):
  - Q<=P with no range check; WrapCount<=0; TerminalCount=0.
- Up (01, CountEnable=1):
  - Sum Q+Step is computed in WIDTH+1 bits.
  - If Q>=EndCount or the sum is >EndCount: wrap event, Q<=BeginCount.
  - Otherwise Q<=Q+Step.
- Down (10, CountEnable=1):
  - Difference Q-Step is computed in WIDTH+1 bits, signed.
  - If Q<=BeginCount or the difference is <BeginCount: wrap event, Q<=EndCount.
  - Otherwise Q<=Q-Step.
- Wrap event: TerminalCount<=1 for that cycle; WrapCount<=WrapCount+1, holding at 2^CW-1.
- Out-of-window Q (e.g. after a load):
  - Up with Q>EndCount wraps to BeginCount.
  - Down with Q<BeginCount wraps to EndCount.
- Degenerate window BeginCount>EndCount: every up or down count is a wrap event (bounds are still loaded as stated). This is not an error.
- BeginCount==EndCount: every enabled count is a wrap event; Q stays at the bound.
- Window, Step and mode changes take effect on the next edge; there is no internal latching of bounds.

## Timing
- All outputs are registered; latency is one CLK edge from S/CountEnable/P/bounds to Q.
- TerminalCount is high exactly in the cycle in which Q holds the wrapped value. Back-to-back wraps give a continuous high.
- Reset mid-operation clears Q, TerminalCount and WrapCount immediately, regardless of CLK.
- No handshake; inputs must be stable around the CLK edge only.

## Configuration
- UNIVERSAL_COUNTER_SATURATE_EN defined:
  - Up stops at EndCount: Q<=EndCount instead of BeginCount.
  - Down stops at BeginCount: Q<=BeginCount instead of EndCount.
  - The terminal event (TerminalCount pulse, WrapCount increment) fires on every enabled count that would cross the bound or starts at the bound.
  - Out-of-window Q is clamped to the nearer crossed bound.
- Macro undefined: wrap behaviour as in Operation.

## Structure
- Package universal_counter_pkg holds:
  - mode constants MODE_HOLD=2'b00, MODE_UP=2'b01, MODE_DOWN=2'b10, MODE_LOAD=2'b11;
  - a typedef for the 2-bit mode.
- Sub-module universal_counter_next:
  - purely combinational;
  - computes next Q and the terminal flag from Q, S, CountEnable, Step, bounds and P;
  - the saturate/wrap choice lives here.
- The top level holds the Q, TerminalCount and WrapCount registers.

## Test plan
All cases use WIDTH=10, CW=8, RESET_VALUE=0.
- Reset then load: RESET_N=0 -> Q=0, TC=0, WrapCount=0. Then S=11, P=100 -> Q=100 next edge, WrapCount=0.
- Up wrap:
  - Setup: Begin=10, End=20, Step=3, Q=18, S=01.
  - Next edge: sum 21>20, so Q=10, TC=1, WrapCount=1.
  - Following edge: Q=13, TC=0.
- Down wrap: Begin=10, End=20, Step=4, Q=12, S=10 -> Q=20, TC=1.
- Enable and Step=0:
  - CountEnable=0 with S=01 for 5 cycles -> Q constant, TC=0.
  - Step=0, Q=5, End=1023 -> Q=6.
- Full-range overflow and saturation:
  - Begin=0, End=1023, Step=1, Q=1023, S=01 -> Q=0, TC=1.
  - WrapCount saturates at 255 after 300 wraps.
- Async reset and saturate build:
  - RESET_N pulsed low mid-count between edges -> Q=0 immediately.
  - With UNIVERSAL_COUNTER_SATURATE_EN, up from Q=20 (End=20) -> Q=20, TC=1 every cycle.
